// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcode constants and the 1149.1 TMS graph.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam int unsigned IDCODE_OP = 1;

    // All-ones opcode for an IR of the given width.
    function automatic int unsigned bypass_op(input int unsigned ir_width);
        return (32'd1 << ir_width) - 32'd1;
    endfunction

    function automatic tap_state_t next_state(input logic tms, input tap_state_t state);
        tap_state_t nxt;
        case (state)
            TLR:     nxt = tms ? TLR    : RTI;
            RTI:     nxt = tms ? SEL_DR : RTI;
            SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
            SH_DR:   nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:  nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR:  nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:  nxt = tms ? SEL_DR : RTI;
            SEL_IR:  nxt = tms ? TLR    : CAP_IR;
            CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
            SH_IR:   nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:  nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR:  nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:  nxt = tms ? SEL_DR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; advances on every rising TCK edge.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tms,
    output logic [3:0] tap_state
);

    tap_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = TLR;
        state_d   = next_state(tms, state_q);
        tap_state = state_q;
    end

endmodule

// File: rtl/jtag_tap_multi.sv
// TAP with configurable IR, IDCODE, BYPASS and NUM_USER user data registers.
module jtag_tap_multi
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE        = 32'h1000_0001,
    parameter int unsigned NUM_USER      = 2,
    parameter int unsigned USER_DR_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tms,
    input  logic                              tdi,
    output logic                              tdo,
    output logic                              tdo_oe,
    output logic [3:0]                        tap_state,
    output logic [IR_WIDTH-1:0]               ir_out,
    input  logic [NUM_USER*USER_DR_WIDTH-1:0] user_dr_in,
    output logic [NUM_USER*USER_DR_WIDTH-1:0] user_dr_out,
    output logic [NUM_USER-1:0]               user_update
);

    localparam int unsigned           UW        = USER_DR_WIDTH;
    localparam logic [IR_WIDTH-1:0]   IR_IDCODE = IR_WIDTH'(IDCODE_OP);

    tap_state_t state, state_nxt;

    logic [IR_WIDTH-1:0]    ir_sr, ir_q;
    logic [31:0]            id_sr;
    logic                   byp_sr;
    logic [UW-1:0]          usr_sr, usr_cap;
    logic [NUM_USER-1:0]    user_hit, user_upd_q;
    logic [NUM_USER*UW-1:0] user_dr_q;
    logic                   sel_id, sel_user;

    jtag_tap_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .tms       (tms),
        .tap_state (tap_state)
    );

    assign state     = tap_state_t'(tap_state);
    assign state_nxt = next_state(tms, state);

    // Opcodes outside IDCODE and the user range fall through to BYPASS.
    always_comb begin
        user_hit = '0;
        usr_cap  = '0;
        for (int i = 0; i < NUM_USER; i++) begin
            user_hit[i] = (ir_q == IR_WIDTH'(i + 2));
            if (user_hit[i]) usr_cap = user_dr_in[i*UW +: UW];
        end
        sel_id   = (ir_q == IR_IDCODE);
        sel_user = |user_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_sr      <= '0;
            ir_q       <= IR_IDCODE;
            id_sr      <= '0;
            byp_sr     <= 1'b0;
            usr_sr     <= '0;
            user_dr_q  <= '0;
            user_upd_q <= '0;
        end else begin
            user_upd_q <= '0;
            case (state)
                CAP_IR: ir_sr <= IR_WIDTH'(1);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir_q  <= ir_sr;
                CAP_DR: begin
                    if (sel_id)        id_sr  <= IDCODE;
                    else if (sel_user) usr_sr <= usr_cap;
                    else               byp_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_id)        id_sr  <= {tdi, id_sr[31:1]};
                    else if (sel_user) usr_sr <= (usr_sr >> 1) | (UW'(tdi) << (UW - 1));
                    else               byp_sr <= tdi;
                end
                UPD_DR: begin
                    if (sel_user) begin
                        for (int i = 0; i < NUM_USER; i++) begin
                            if (user_hit[i]) user_dr_q[i*UW +: UW] <= usr_sr;
                        end
                        user_upd_q <= user_hit;
                    end
                end
                default: ;
            endcase
            // Lookahead so ir_out reads IDCODE in the same cycle tap_state reads TLR.
            if (state_nxt == TLR) ir_q <= IR_IDCODE;
        end
    end

    always_comb begin
        tdo    = 1'b0;
        tdo_oe = (state == SH_IR) || (state == SH_DR);
        if (state == SH_IR) begin
            tdo = ir_sr[0];
        end else if (state == SH_DR) begin
            if (sel_id)        tdo = id_sr[0];
            else if (sel_user) tdo = usr_sr[0];
            else               tdo = byp_sr;
        end
    end

    assign ir_out      = ir_q;
    assign user_dr_out = user_dr_q;
    assign user_update = user_upd_q;

endmodule
